// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequential shift-and-add unsigned multiplier.
// A three-state FSM (IDLE, CALC, DONE) controls a small datapath.
// The datapath holds a 2*WIDTH multiplicand, a WIDTH multiplier shift
// register, a 2*WIDTH accumulator and a bit counter.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: CALC stops as soon as the
// remaining multiplier bits are all zero. The product is the same either way.
module seq_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int P_W   = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               calc_end;
    logic               last;
    logic [P_W-1:0]     mcand;
    logic [WIDTH-1:0]   mplier;
    logic [P_W-1:0]     acc;
    logic [P_W-1:0]     sum;
    logic [CNT_W-1:0]   cnt;

    // The counter marks the final multiplier bit. The sum includes the current bit's partial product.
    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign sum  = acc + (mplier[0] ? mcand : '0);

    // State register; reset forces IDLE regardless of start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        calc_end   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
`ifdef SEQ_MULT_EARLY_TERM_EN
                // Stop once the bits still to be shifted in are all zero.
                calc_end = last || (mplier[WIDTH-1:1] == '0);
`else
                calc_end = last;
`endif
                if (calc_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift-and-add datapath. The product register changes only when a result completes or on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (calc_end) begin
                product <= sum;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Testbench for seq_mult_ctrl. Uses directed scenarios with literal expectations plus randomized traffic.
// A transaction-level reference model is checked against the DUT on every cycle.
module tb_seq_mult_ctrl;

    localparam int W   = 4;
    localparam int P_W = 2 * W;

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           busy;
    logic           done;
    logic [P_W-1:0] product;

    int n_checks = 0;
    int n_errors = 0;
    bit armed = 1'b0;

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Length of the CALC phase for multiplier b.
    function automatic int calc_len(input logic [W-1:0] b);
        int len;
        if (!EARLY) return W;
        len = 1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) len = i + 1;
        end
        return len;
    endfunction

    // Reference model. m_rem counts the edges left until the DUT returns to IDLE.
    // The DUT shows done when m_rem is 1 and shows busy whenever m_rem is nonzero.
    int             m_rem = 0;
    logic [P_W-1:0] m_pend = '0;
    logic [P_W-1:0] m_prod = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  <= 0;
            m_prod <= '0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_rem  <= calc_len(B) + 1;
                m_pend <= P_W'(A) * P_W'(B);
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) m_prod <= m_pend;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model on every cycle, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            check("model_busy",    32'(busy),    32'(m_rem != 0));
            check("model_done",    32'(done),    32'(m_rem == 1));
            check("model_product", 32'(product), 32'(m_prod));
        end
    end

    // Present one request for one cycle. Then check the latency and the product against literal values.
    task automatic run_op(input string name, input int a, input int b, input int exp_p, input int exp_lat);
        int n;
        @(negedge clk);
        A = W'(a); B = W'(b); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check({name, "_busy_after_accept"}, 32'(busy), 32'd1);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
        check({name, "_product"}, 32'(product), 32'(exp_p));
        @(negedge clk);
        check({name, "_done_width"}, 32'(done), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        int lat4;
        lat4 = EARLY ? 0 : W + 1;

        // Reset
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        rst = 1'b0;
        armed = 1'b1;

        // Directed scenarios with literal results. The latency depends on the build.
        run_op("a3b3", 3, 3, 9, EARLY ? 3 : 5);
        run_op("a15b15", 15, 15, 225, 5);
        run_op("a0b7", 0, 7, 0, EARLY ? 4 : 5);
        run_op("a7b0", 7, 0, 0, EARLY ? 2 : 5);
        run_op("a13b1", 13, 1, 13, EARLY ? 2 : 5);
        run_op("a13b8", 13, 8, 104, 5);
        if (lat4 != 0) check("nominal_latency", 32'(lat4), 32'd5);

        // A start during CALC must be ignored.
        @(negedge clk);
        A = 4'd5; B = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 4'd0; B = 4'd0;
        @(negedge clk);
        start = 1'b1; A = 4'd1; B = 4'd1;
        @(negedge clk);
        start = 1'b0; A = 4'd2; B = 4'd3;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("ignored_start_done_count", 32'(ndone), 32'd1);
        check("ignored_start_product", 32'(product), 32'd30);

        // Reset on the second CALC cycle aborts the operation.
        @(negedge clk);
        A = 4'd9; B = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run_op("after_abort", 9, 9, 81, EARLY ? 5 : 5);

        // Hold start high to get back-to-back operations with changing operands.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            A = W'($urandom);
            B = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 3) != 0);
            A = W'($urandom);
            B = W'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4: operand width in bits, legal range 2..16.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a multiplication, sampled only in IDLE.
REQ-005 The module SHALL have port A, input, WIDTH bits: unsigned multiplicand, captured on accept.
REQ-006 The module SHALL have port B, input, WIDTH bits: unsigned multiplier, captured on accept.
REQ-007 The module SHALL have port busy, output, 1 bit: high while in CALC or DONE.
REQ-008 The module SHALL have port done, output, 1 bit: single-cycle pulse marking product valid.
REQ-009 The module SHALL have port product, output, 2*WIDTH bits: registered result A*B.

Function
REQ-010 The FSM SHALL have states IDLE, CALC and DONE, fully encoded, with no unreachable state left unhandled; any illegal state SHALL go to IDLE.
REQ-011 The module SHALL accept a request at the rising edge where state=IDLE and start=1.
REQ-012 On accept, the module SHALL: latch A into a 2*WIDTH multiplicand register (zero-extended); latch B into a WIDTH multiplier shift register; clear the accumulator and the bit counter; enter CALC.
REQ-013 At each CALC edge, if the multiplier LSB=1, the module SHALL add the multiplicand to the accumulator; it SHALL then shift the multiplicand left by 1 and the multiplier right by 1, and increment the counter.
REQ-014 The accumulator SHALL be 2*WIDTH bits and unsigned; overflow is impossible and SHALL NOT be flagged.
REQ-015 CALC SHALL last exactly WIDTH cycles; on the WIDTH-th CALC edge, the module SHALL load the final sum into product and enter DONE.
REQ-016 done SHALL be 1 only during the DONE cycle, i.e., WIDTH+1 cycles after the accept edge; the next edge SHALL return the FSM to IDLE.
REQ-017 product SHALL hold its value from DONE until the next result is loaded; it SHALL NOT change on accept or during CALC.
REQ-018 start while in CALC or DONE SHALL be ignored; it SHALL NOT be queued, and A/B changes while busy SHALL NOT affect the result.
REQ-019 start held high continuously SHALL cause back-to-back operations, with one IDLE cycle between each done and the next accept.
REQ-020 busy SHALL be 0 in IDLE and 1 in CALC and DONE.

Reset
REQ-021 On an edge with rst=1, the module SHALL set state=IDLE, busy=0, done=0, product=0, and clear the accumulator, counter and operand registers; rst SHALL take priority over start.
REQ-022 A reset asserted during CALC or DONE SHALL abort the operation: no done pulse, and product=0.

Configuration
REQ-023 With macro SEQ_MULT_EARLY_TERM_EN defined, CALC SHALL end on the first edge at which the post-shift multiplier register is zero; CALC length SHALL be max(1, index of highest set bit of B + 1) cycles, and done SHALL follow in the next cycle.
REQ-024 Without SEQ_MULT_EARLY_TERM_EN, CALC SHALL always last WIDTH cycles per REQ-015; the results SHALL be identical in both builds.

Verification
REQ-025 Scenario (WIDTH=4, macro off): A=3, B=3, start 1 cycle -> busy high next cycle; done pulses 5 cycles after accept; product=9.
REQ-026 Scenario: A=15, B=15 -> product=225 (0xE1); done is exactly 1 cycle wide.
REQ-027 Scenario: A=0, B=7, then A=7, B=0 -> product=0 both times; the prior product holds until each done.
REQ-028 Scenario: accept A=5, B=6, then pulse start with A=1, B=1 during CALC -> product=30 and only one done pulse.
REQ-029 Scenario: accept A=9, B=9, assert rst on the 2nd CALC cycle -> no done, product=0, IDLE; a new start then yields a correct result.
REQ-030 Scenario (macro on): A=13, B=1 -> done 2 cycles after accept, product=13; A=13, B=8 -> done 5 cycles after accept, product=104.
